// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, prefix FSM states and the queued key-event record.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;
  localparam logic [7:0] CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } key_evt_t;

  // Keyboard status/ack bytes that carry no key meaning when seen outside a prefix.
  function automatic logic is_idle_drop(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational set-2 scan code to ASCII lookup (US layout); zero latency, no flow control.
// Extended codes and anything unmapped translate to 0x00.
module ps2_keymap (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  always_comb begin
    ascii  = 8'h00;
    letter = 8'h00;
    case (code)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      8'h16: ascii = shift ? "!" : "1";
      8'h1E: ascii = shift ? "@" : "2";
      8'h26: ascii = shift ? "#" : "3";
      8'h25: ascii = shift ? "$" : "4";
      8'h2E: ascii = shift ? "%" : "5";
      8'h36: ascii = shift ? "^" : "6";
      8'h3D: ascii = shift ? "&" : "7";
      8'h3E: ascii = shift ? "*" : "8";
      8'h46: ascii = shift ? "(" : "9";
      8'h45: ascii = shift ? ")" : "0";
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      8'h0D: ascii = 8'h09;
      8'h76: ascii = 8'h1B;
      default: ;
    endcase
    if (letter != 8'h00) begin
      ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
    end
    if (ext) begin
      ascii = 8'h00;
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// Resolves E0/F0 prefixes and Shift/Caps state, queueing translated key events in a FIFO.
// Event visible one cycle after its final byte; consumer stalls via evt_ready, full FIFO drops and flags overflow.
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_ascii,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       shift_active,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  ps2_state_e state_q, state_d;
  logic lshift_q, lshift_d, rshift_q, rshift_d;
  logic caps_lock_q, caps_lock_d, caps_held_q, caps_held_d;
  logic overflow_q, overflow_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  key_evt_t mem_q [FIFO_DEPTH];
  key_evt_t mem_d [FIFO_DEPTH];

  logic       drop, complete, cur_brk, cur_ext;
  logic       full, empty, push, pop;
  logic [7:0] new_ascii;
  key_evt_t   new_evt, head;

  ps2_keymap u_keymap (
    .code  (code_in),
    .ext   (cur_ext),
    .shift (lshift_q | rshift_q),
    .caps  (caps_lock_q),
    .ascii (new_ascii)
  );

  always_comb begin
    cur_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    cur_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    drop     = (code_in == PS2_PAUSE) || ((state_q == ST_IDLE) && is_idle_drop(code_in));
    complete = code_valid && !drop && (code_in != PS2_EXT) && (code_in != PS2_BRK);
    new_evt  = '{ascii: new_ascii, code: code_in, brk: cur_brk, ext: cur_ext};

    state_d = state_q;
    if (code_valid && !drop) begin
      case (code_in)
        PS2_EXT: state_d = (state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
        PS2_BRK: begin
          if (state_q == ST_IDLE)     state_d = ST_BRK;
          else if (state_q == ST_EXT) state_d = ST_EXT_BRK;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Caps toggles only on the first press of a hold so typematic repeats are ignored.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_lock_d = caps_lock_q;
    caps_held_d = caps_held_q;
    if (complete && !cur_ext) begin
      if (code_in == LSHIFT) lshift_d = !cur_brk;
      if (code_in == RSHIFT) rshift_d = !cur_brk;
      if (code_in == CAPS) begin
        if (cur_brk) begin
          caps_held_d = 1'b0;
        end else begin
          if (!caps_held_q) caps_lock_d = !caps_lock_q;
          caps_held_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !empty && evt_ready;
    push       = complete && (!full || pop);
    overflow_d = overflow_q || (complete && full && !pop);
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = new_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_lock_q <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_lock_q <= caps_lock_d;
      caps_held_q <= caps_held_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_valid    = !empty;
  assign evt_ascii    = head.ascii;
  assign evt_code     = head.code;
  assign evt_break    = head.brk;
  assign evt_ext      = head.ext;
  assign shift_active = lshift_q | rshift_q;
  assign caps_lock    = caps_lock_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed scan-code sequences with hand-computed events queued to a scoreboard;
// a negedge monitor pops and compares each accepted event and checks stall stability.
module tb_ps2_key_event;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] code_in;
  logic       code_valid;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_ascii;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       shift_active;
  logic       caps_lock;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_key_event #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .evt_ready    (evt_ready),
    .evt_valid    (evt_valid),
    .evt_ascii    (evt_ascii),
    .evt_code     (evt_code),
    .evt_break    (evt_break),
    .evt_ext      (evt_ext),
    .shift_active (shift_active),
    .caps_lock    (caps_lock),
    .overflow     (overflow)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] c;
    logic       b;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_evt(input logic [7:0] a, input logic [7:0] c, input logic b, input logic e);
    exp_t x;
    x.a = a; x.c = c; x.b = b; x.e = e;
    q.push_back(x);
  endtask

  // Monitor: samples on the falling edge, away from the capturing edge.
  logic        stall_p = 1'b0;
  logic [17:0] held = '0;
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && evt_valid) begin
      if (stall_p) chk("stall_stable", {14'd0, evt_ascii, evt_code, evt_break, evt_ext}, {14'd0, held});
      if (evt_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got code %0h ascii %0h, expected none", evt_code, evt_ascii);
        end else begin
          x = q.pop_front();
          chk("evt_ascii", evt_ascii, x.a);
          chk("evt_code", evt_code, x.c);
          chk("evt_break", evt_break, x.b);
          chk("evt_ext", evt_ext, x.e);
        end
      end
      stall_p = !evt_ready;
      held    = {evt_ascii, evt_code, evt_break, evt_ext};
    end else begin
      stall_p = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    code_in    = b;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) idle(1);
    idle(2);
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    code_in    = 8'h00;
    code_valid = 1'b0;
    evt_ready  = 1'b1;
    idle(3);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_ascii", evt_ascii, 0);
    chk("rst_evt_code", evt_code, 0);
    chk("rst_shift", shift_active, 0);
    chk("rst_caps", caps_lock, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    idle(2);

    // Plain press/release with latency check
    expect_evt(8'h61, 8'h1C, 1'b0, 1'b0);
    code_in    = 8'h1C;
    code_valid = 1'b1;
    chk("lat_before", evt_valid, 0);
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    chk("lat_after", evt_valid, 1);
    idle(3);
    expect_evt(8'h61, 8'h1C, 1'b1, 1'b0);
    send(8'hF0);
    chk("brk_prefix_no_evt", evt_valid, 0);
    send(8'h1C);
    chk("brk_lat", evt_valid, 1);
    wait_drain();

    // Shift
    expect_evt(8'h00, 8'h12, 1'b0, 1'b0);
    send(8'h12);
    chk("shift_on", shift_active, 1);
    expect_evt(8'h41, 8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    expect_evt(8'h00, 8'h12, 1'b1, 1'b0);
    send(8'hF0); send(8'h12);
    chk("shift_off", shift_active, 0);
    expect_evt(8'h61, 8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    wait_drain();

    // Caps Lock with typematic repeats
    for (int i = 0; i < 3; i++) begin
      expect_evt(8'h00, 8'h58, 1'b0, 1'b0);
      send(8'h58);
      chk("caps_after_press", caps_lock, 1);
    end
    expect_evt(8'h00, 8'h58, 1'b1, 1'b0);
    send(8'hF0); send(8'h58);
    chk("caps_after_release", caps_lock, 1);
    expect_evt(8'h41, 8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    expect_evt(8'h00, 8'h12, 1'b0, 1'b0);
    send(8'h12);
    expect_evt(8'h21, 8'h16, 1'b0, 1'b0);
    send(8'h16);
    expect_evt(8'h00, 8'h12, 1'b1, 1'b0);
    send(8'hF0); send(8'h12);
    expect_evt(8'h00, 8'h58, 1'b0, 1'b0);
    send(8'h58);
    chk("caps_toggle_off", caps_lock, 0);
    expect_evt(8'h00, 8'h58, 1'b1, 1'b0);
    send(8'hF0); send(8'h58);
    wait_drain();

    // Extended codes, ignored status byte, pause byte inside a prefix
    expect_evt(8'h00, 8'h75, 1'b0, 1'b1);
    send(8'hE0); send(8'h75);
    expect_evt(8'h00, 8'h75, 1'b1, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    wait_drain();
    send(8'hAA);
    idle(3);
    chk("aa_no_evt", evt_valid, 0);
    expect_evt(8'h00, 8'h75, 1'b0, 1'b1);
    send(8'hE0); send(8'hE1); send(8'h75);
    wait_drain();

    // Overflow: consumer stalled, 5 events into a 4-deep FIFO
    evt_ready = 1'b0;
    expect_evt(8'h61, 8'h1C, 1'b0, 1'b0);
    expect_evt(8'h62, 8'h32, 1'b0, 1'b0);
    expect_evt(8'h63, 8'h21, 1'b0, 1'b0);
    expect_evt(8'h64, 8'h23, 1'b0, 1'b0);
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    chk("full_no_overflow", overflow, 0);
    send(8'h24);
    chk("overflow_set", overflow, 1);
    chk("full_valid", evt_valid, 1);
    idle(4);
    expect_evt(8'h66, 8'h2B, 1'b0, 1'b0);
    evt_ready = 1'b1;
    send(8'h2B);
    wait_drain();
    chk("overflow_sticky", overflow, 1);

    // Reset mid-prefix
    expect_evt(8'h00, 8'h58, 1'b0, 1'b0);
    send(8'h58);
    chk("caps_before_reset", caps_lock, 1);
    wait_drain();
    send(8'hE0); send(8'hF0);
    rst_n = 1'b0;
    idle(2);
    chk("rst2_evt_valid", evt_valid, 0);
    chk("rst2_caps", caps_lock, 0);
    chk("rst2_overflow", overflow, 0);
    rst_n = 1'b1;
    idle(2);
    chk("rst2_empty", evt_valid, 0);
    expect_evt(8'h61, 8'h1C, 1'b0, 1'b0);
    send(8'h1C);
    wait_drain();

    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
